// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator motion/request controller.
package elevator_pkg;

    localparam int FLOOR_W = 4;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        MOVING,
        STEP,
        CHECK,
        DOOR_OPEN
    } state_t;

endpackage

// File: rtl/elevator_if.sv
// Bus between the elevator controller, the call-button logic and the floor counter.
// With EMERG_STOP_EN defined the bus also carries the emerg stop input.
interface elevator_if #(
    parameter int N_FLOORS = 16,
    parameter int FLOOR_W  = 4
);
    logic [N_FLOORS-1:0] call_req;
    logic [FLOOR_W-1:0]  andar_atual;
    logic                C;
    logic                habilitar;
    logic                porta_aberta;
    logic [N_FLOORS-1:0] pending;
    logic                ocupado;
`ifdef EMERG_STOP_EN
    logic                emerg;

    modport master (
        input  call_req, andar_atual, emerg,
        output C, habilitar, porta_aberta, pending, ocupado
    );
    modport slave (
        output call_req, andar_atual, emerg,
        input  C, habilitar, porta_aberta, pending, ocupado
    );
`else
    modport master (
        input  call_req, andar_atual,
        output C, habilitar, porta_aberta, pending, ocupado
    );
    modport slave (
        output call_req, andar_atual,
        input  C, habilitar, porta_aberta, pending, ocupado
    );
`endif
endinterface

// File: rtl/elevator_req_scan.sv
// Classifies outstanding calls relative to the current floor: here, above, below, ahead of travel.
module elevator_req_scan
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 16,
    parameter int FLOOR_W  = 4
)(
    input  logic [N_FLOORS-1:0] pend_i,
    input  logic [FLOOR_W-1:0]  floor_i,
    input  logic                dir_i,
    output logic                here_o,
    output logic                above_o,
    output logic                below_o,
    output logic                ahead_o
);

    always_comb begin
        here_o  = 1'b0;
        above_o = 1'b0;
        below_o = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pend_i[i]) begin
                if (i == int'(floor_i))     here_o  = 1'b1;
                else if (i > int'(floor_i)) above_o = 1'b1;
                else                        below_o = 1'b1;
            end
        end
        ahead_o = (dir_i == UP) ? above_o : below_o;
    end

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: latches calls, steps the floor counter and times the door.
// Optional EMERG_STOP_EN adds an emerg input that freezes motion while held.
module elevator_ctrl #(
    parameter int N_FLOORS      = 16,
    parameter int FLOOR_W       = 4,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
)(
    input logic      clk,
    input logic      clear,
    elevator_if.master bus
);
    import elevator_pkg::*;

    localparam int TMR_W = 16;
    localparam logic [N_FLOORS-1:0] ONE_HOT0 = N_FLOORS'(1);

    state_t              state_q;
    logic [TMR_W-1:0]    timer_q;
    logic                dir_q;
    logic                hab_q;
    logic                door_q;
    logic                busy_q;
    logic [N_FLOORS-1:0] pending_q;
    logic [N_FLOORS-1:0] pending_d;

    logic [N_FLOORS-1:0] pend_all;
    logic [N_FLOORS-1:0] here_bit;
    logic [N_FLOORS-1:0] clr_mask;
    logic                here;
    logic                above_any;
    logic                below_any;
    logic                ahead_any;
    logic                run;
    logic                here_call;

`ifdef EMERG_STOP_EN
    assign run = ~bus.emerg;
`else
    assign run = 1'b1;
`endif

    assign pend_all  = pending_q | bus.call_req;
    assign here_bit  = ONE_HOT0 << bus.andar_atual;
    assign here_call = |(bus.call_req & here_bit);
    // The served floor's bit is masked every door cycle, so a repeat call there never latches.
    assign clr_mask  = (state_q == DOOR_OPEN) ? here_bit : '0;
    assign pending_d = (pending_q | bus.call_req) & ~clr_mask;

    elevator_req_scan #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_scan (
        .pend_i  (pend_all),
        .floor_i (bus.andar_atual),
        .dir_i   (dir_q),
        .here_o  (here),
        .above_o (above_any),
        .below_o (below_any),
        .ahead_o (ahead_any)
    );

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Outputs are loaded on the transition into the state they belong to, so they are pure flops.
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= IDLE;
            timer_q <= '0;
            dir_q   <= UP;
            hab_q   <= 1'b0;
            door_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            hab_q <= 1'b0;
            if (run) begin
                case (state_q)
                    IDLE: begin
                        timer_q <= '0;
                        if (here) begin
                            state_q <= DOOR_OPEN;
                            door_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end else if (above_any || below_any) begin
                            state_q <= MOVING;
                            busy_q  <= 1'b1;
                            // Calls on both sides keep the previous direction.
                            if (!(above_any && below_any)) begin
                                dir_q <= below_any ? DOWN : UP;
                            end
                        end
                    end
                    MOVING: begin
                        if (timer_q == TMR_W'(TRAVEL_CYCLES - 1)) begin
                            state_q <= STEP;
                            timer_q <= '0;
                            hab_q   <= 1'b1;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    STEP: begin
                        state_q <= CHECK;
                    end
                    CHECK: begin
                        timer_q <= '0;
                        if (here) begin
                            state_q <= DOOR_OPEN;
                            door_q  <= 1'b1;
                        end else if (ahead_any) begin
                            state_q <= MOVING;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    DOOR_OPEN: begin
                        if (here_call) begin
                            timer_q <= '0;
                        end else if (timer_q == TMR_W'(DOOR_CYCLES - 1)) begin
                            state_q <= IDLE;
                            timer_q <= '0;
                            door_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            timer_q <= timer_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        timer_q <= '0;
                        door_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.C            = dir_q;
    assign bus.habilitar    = hab_q;
    assign bus.porta_aberta = door_q;
    assign bus.pending      = pending_q;
    assign bus.ocupado      = busy_q;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with a behavioural floor counter driven by C/habilitar.
module tb_elevator_ctrl;

    logic       clk;
    logic       clear;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] floor_q;
    int         checks;
    int         errors;

    elevator_if #(.N_FLOORS(16), .FLOOR_W(4)) ifc ();

    elevator_ctrl #(
        .N_FLOORS      (16),
        .FLOOR_W       (4),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (8)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Floor counter model: steps on the edge where habilitar is high.
    always @(posedge clk) begin
        if (load) floor_q <= load_val;
        else if (ifc.habilitar) floor_q <= ifc.C ? floor_q - 4'd1 : floor_q + 4'd1;
    end
    assign ifc.andar_atual = floor_q;

    task automatic set_floor(input int f);
        load     = 1'b1;
        load_val = 4'(f);
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic pulse_call(input logic [15:0] bits);
        ifc.call_req = bits;
        @(negedge clk);
        ifc.call_req = '0;
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #1;
        checks++;
        if ({ifc.C, ifc.habilitar, ifc.porta_aberta, ifc.ocupado} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ifc.C, ifc.habilitar, ifc.porta_aberta, ifc.ocupado});
        end
        checks++;
        if (ifc.pending !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pending: got %h expected 0000", ifc.pending);
        end
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_call();
        int pulses, door_cnt, door_first;
        int p_idx[3];
        set_floor(0);
        pulse_call(16'h0008);
        checks++;
        if (ifc.C !== 1'b0 || ifc.ocupado !== 1'b1 || ifc.pending[3] !== 1'b1) begin
            errors++;
            $display("FAIL single_start: C=%b ocupado=%b pend3=%b expected 0 1 1", ifc.C, ifc.ocupado, ifc.pending[3]);
        end
        pulses = 0; door_cnt = 0; door_first = -1;
        p_idx[0] = -1; p_idx[1] = -1; p_idx[2] = -1;
        for (int k = 0; k < 40; k++) begin
            if (ifc.habilitar === 1'b1) begin
                if (pulses < 3) p_idx[pulses] = k;
                pulses++;
            end
            if (ifc.porta_aberta === 1'b1) begin
                if (door_first < 0) door_first = k;
                door_cnt++;
            end
            @(negedge clk);
        end
        checks++;
        if (pulses != 3) begin
            errors++;
            $display("FAIL single_pulses: got %0d expected 3", pulses);
        end
        checks++;
        if (p_idx[0] != 4 || p_idx[1] != 10 || p_idx[2] != 16) begin
            errors++;
            $display("FAIL single_spacing: got %0d %0d %0d expected 4 10 16", p_idx[0], p_idx[1], p_idx[2]);
        end
        checks++;
        if (door_first != 18 || door_cnt != 8) begin
            errors++;
            $display("FAIL single_door: first=%0d cnt=%0d expected 18 8", door_first, door_cnt);
        end
        checks++;
        if (floor_q !== 4'd3 || ifc.pending !== 16'h0000 || ifc.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL single_end: floor=%0d pend=%h ocupado=%b expected 3 0000 0", floor_q, ifc.pending, ifc.ocupado);
        end
    endtask

    task automatic test_call_here();
        int door_cnt, pulses;
        logic pend_seen;
        set_floor(5);
        pulse_call(16'h0020);
        checks++;
        if (ifc.porta_aberta !== 1'b1 || ifc.habilitar !== 1'b0) begin
            errors++;
            $display("FAIL here_open: porta=%b hab=%b expected 1 0", ifc.porta_aberta, ifc.habilitar);
        end
        door_cnt = 0; pulses = 0; pend_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (ifc.porta_aberta === 1'b1) door_cnt++;
            if (ifc.habilitar === 1'b1) pulses++;
            if (k >= 6 && ifc.pending[5] !== 1'b0) pend_seen = 1'b1;
            ifc.call_req = (k == 5) ? 16'h0020 : 16'h0000;
            @(negedge clk);
        end
        ifc.call_req = '0;
        checks++;
        if (door_cnt != 14) begin
            errors++;
            $display("FAIL here_restart: door cycles %0d expected 14", door_cnt);
        end
        checks++;
        if (pulses != 0 || pend_seen !== 1'b0) begin
            errors++;
            $display("FAIL here_nolatch: pulses=%0d pend_seen=%b expected 0 0", pulses, pend_seen);
        end
    endtask

    task automatic test_scan();
        int up_p, dn_p, door_first, door_cnt;
        logic c_before, c_after, busy_mid;
        set_floor(4);
        checks++;
        if (ifc.C !== 1'b0) begin
            errors++;
            $display("FAIL scan_prevdir: C=%b expected 0", ifc.C);
        end
        pulse_call(16'h0084);
        up_p = 0; dn_p = 0; door_first = -1; door_cnt = 0;
        c_before = 1'bx; c_after = 1'bx; busy_mid = 1'bx;
        for (int k = 0; k < 70; k++) begin
            if (ifc.habilitar === 1'b1) begin
                if (ifc.C === 1'b0) up_p++;
                else dn_p++;
            end
            if (ifc.porta_aberta === 1'b1) begin
                if (door_first < 0) door_first = k;
                door_cnt++;
            end
            if (k == 26) begin c_before = ifc.C; busy_mid = ifc.ocupado; end
            if (k == 27) c_after = ifc.C;
            @(negedge clk);
        end
        checks++;
        if (up_p != 3 || dn_p != 5) begin
            errors++;
            $display("FAIL scan_steps: up=%0d down=%0d expected 3 5", up_p, dn_p);
        end
        checks++;
        if (door_first != 18 || door_cnt != 16) begin
            errors++;
            $display("FAIL scan_doors: first=%0d cnt=%0d expected 18 16", door_first, door_cnt);
        end
        checks++;
        if (busy_mid !== 1'b0 || c_before !== 1'b0 || c_after !== 1'b1) begin
            errors++;
            $display("FAIL scan_reverse: ocupado=%b C=%b->%b expected 0 0->1", busy_mid, c_before, c_after);
        end
        checks++;
        if (floor_q !== 4'd2 || ifc.pending !== 16'h0000) begin
            errors++;
            $display("FAIL scan_end: floor=%0d pend=%h expected 2 0000", floor_q, ifc.pending);
        end
    endtask

    task automatic test_boundary();
        int pulses, adjacent, door_cnt;
        logic prev_hab;
        set_floor(15);
        pulse_call(16'h0001);
        checks++;
        if (ifc.C !== 1'b1) begin
            errors++;
            $display("FAIL bound_dir: C=%b expected 1", ifc.C);
        end
        pulses = 0; adjacent = 0; door_cnt = 0; prev_hab = 1'b0;
        for (int k = 0; k < 110; k++) begin
            if (ifc.habilitar === 1'b1) begin
                pulses++;
                if (prev_hab) adjacent++;
            end
            if (ifc.porta_aberta === 1'b1) door_cnt++;
            prev_hab = (ifc.habilitar === 1'b1);
            @(negedge clk);
        end
        checks++;
        if (pulses != 15 || adjacent != 0) begin
            errors++;
            $display("FAIL bound_pulses: pulses=%0d adjacent=%0d expected 15 0", pulses, adjacent);
        end
        checks++;
        if (floor_q !== 4'd0 || door_cnt != 8 || ifc.ocupado !== 1'b0) begin
            errors++;
            $display("FAIL bound_end: floor=%0d door=%0d ocupado=%b expected 0 8 0", floor_q, door_cnt, ifc.ocupado);
        end
    endtask

    task automatic test_reset_mid();
        set_floor(3);
        pulse_call(16'h0002);
        @(negedge clk);
        checks++;
        if (ifc.C !== 1'b1 || ifc.ocupado !== 1'b1) begin
            errors++;
            $display("FAIL midrst_pre: C=%b ocupado=%b expected 1 1", ifc.C, ifc.ocupado);
        end
        #2;
        clear = 1'b0;
        #1;
        checks++;
        if ({ifc.C, ifc.habilitar, ifc.porta_aberta, ifc.ocupado} !== 4'b0000 || ifc.pending !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_async: ctrl=%b pend=%h expected 0000 0000",
                     {ifc.C, ifc.habilitar, ifc.porta_aberta, ifc.ocupado}, ifc.pending);
        end
        @(negedge clk);
        clear = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.ocupado !== 1'b0 || floor_q !== 4'd3) begin
            errors++;
            $display("FAIL midrst_idle: ocupado=%b floor=%0d expected 0 3", ifc.ocupado, floor_q);
        end
    endtask

`ifdef EMERG_STOP_EN
    task automatic test_emerg();
        int pulses, held, door_cnt;
        set_floor(2);
        pulse_call(16'h0008);
        pulses = 0; held = 0; door_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            if (ifc.habilitar === 1'b1) begin
                pulses++;
                if (k >= 4 && k <= 8) held++;
            end
            if (ifc.porta_aberta === 1'b1) door_cnt++;
            ifc.emerg = (k >= 3 && k < 8);
            @(negedge clk);
        end
        ifc.emerg = 1'b0;
        checks++;
        if (pulses != 1 || held != 0) begin
            errors++;
            $display("FAIL emerg_pulse: pulses=%0d during_emerg=%0d expected 1 0", pulses, held);
        end
        checks++;
        if (floor_q !== 4'd3 || door_cnt != 8) begin
            errors++;
            $display("FAIL emerg_end: floor=%0d door=%0d expected 3 8", floor_q, door_cnt);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        clear        = 1'b1;
        load         = 1'b0;
        load_val     = 4'd0;
        floor_q      = 4'd0;
        ifc.call_req = '0;
`ifdef EMERG_STOP_EN
        ifc.emerg    = 1'b0;
`endif
        #2;
        test_reset();
        test_single_call();
        test_call_here();
        test_scan();
        test_boundary();
        test_reset_mid();
`ifdef EMERG_STOP_EN
        test_emerg();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
